seq_shift_add_mult: RTL and testbench

Parametrised sequential shift-add multiplier for unsigned mantissas. It is the next-generation multiply core for the floating-point multiply path: W-bit operands in, 2W-bit product out. Start/busy/done handshake, operand capture at start, product held until the next operation. Sits between the FP unpack stage (mantissa with hidden bit) and the normalise/round stage.

---
 rtl/seq_shift_add_mult.sv | 103 ++++++++++
 tb/tb_seq_shift_add_mult.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier for unsigned mantissas: WIDTH-bit operands, 2*WIDTH-bit product.
// Latency: WIDTH RUN cycles after the accepting edge; with EARLY_TERM_EN, ends after the highest set bit of b.
// Backpressure: start is taken only while ready=1 (IDLE/DONE); starts during RUN are dropped.
module seq_shift_add_mult #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_iter;

  assign accept  = start & ready;
  // mcand starts in the low half and shifts left at most WIDTH-1 times, so the sum cannot overflow
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef EARLY_TERM_EN
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      zero    <= 1'b1;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_iter) begin
        product <= acc_sum;
        zero    <= (acc_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult at WIDTH=24: directed vector table, back-to-back, reset-abort and random operands.
// Latency expectations follow EARLY_TERM_EN when the bench is built with that macro.
module tb_seq_shift_add_mult;

  localparam int W = 24;

  logic           clk;
  logic           resetn;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           zero;

  int checks;
  int failures;
  logic [2*W-1:0] last_prod;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    logic           zero;
    int             lat_early;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RUN cycles the block should spend on multiplier value bv
  function automatic int model_edges(input logic [W-1:0] bv);
    int e;
    e = W;
`ifdef EARLY_TERM_EN
    e = 1;
    for (int i = 0; i < W; i++) if (bv[i]) e = i + 1;
`endif
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tbv);
    check("ready_at_start", {63'b0, ready}, 64'd1);
    start = 1'b1;
    a     = ta;
    b     = tbv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Called just after the accepting edge; returns at the negedge inside the done cycle
  task automatic finish_op(input logic [2*W-1:0] exp_p, input logic exp_z, input int exp_e,
                           input bit noise, input string name);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (done) begin
        got   = 1'b1;
        start = 1'b0;
      end else begin
        check({name, "_busy"}, {63'b0, busy}, 64'd1);
        if (n == 1) check({name, "_prod_hold"}, 64'(product), 64'(last_prod));
        if (noise) begin
          start = 1'($urandom);
          a     = W'($urandom);
          b     = W'($urandom);
        end
      end
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'(exp_e + 1));
    if (got) begin
      check({name, "_product"}, 64'(product), 64'(exp_p));
      check({name, "_zero"}, {63'b0, zero}, {63'b0, exp_z});
      check({name, "_busy_off"}, {63'b0, busy}, 64'd0);
      check({name, "_ready"}, {63'b0, ready}, 64'd1);
    end
    last_prod = exp_p;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [2*W-1:0] exp_p,
                        input logic exp_z, input int exp_e, input bit noise, input string name);
    @(negedge clk);
    launch(ta, tbv);
    finish_op(exp_p, exp_z, exp_e, noise, name);
    @(negedge clk);
    check({name, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2*W-1:0] rp;

    checks    = 0;
    failures  = 0;
    last_prod = '0;

    vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b0, 24};
    vecs[1] = '{24'hC00000, 24'hC00000, 48'h900000000000, 1'b0, 24};
    vecs[2] = '{24'h800000, 24'h800000, 48'h400000000000, 1'b0, 24};
    vecs[3] = '{24'h123456, 24'h000000, 48'h0,            1'b1, 1};
    vecs[4] = '{24'h000005, 24'h000003, 48'hF,            1'b0, 2};
    vecs[5] = '{24'h000001, 24'h000001, 48'h1,            1'b0, 1};
    vecs[6] = '{24'hFFFFFF, 24'h000001, 48'hFFFFFF,       1'b0, 1};
    vecs[7] = '{24'h000000, 24'hFFFFFF, 48'h0,            1'b1, 24};
    vecs[8] = '{24'h000002, 24'h000003, 48'h6,            1'b0, 2};
    vecs[9] = '{24'h000007, 24'h000009, 48'h3F,           1'b0, 4};

    resetn = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("rst_product", 64'(product), 64'd0);
    check("rst_zero", {63'b0, zero}, 64'd1);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, ready}, 64'd1);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef EARLY_TERM_EN
      lat = vecs[i].lat_early;
`else
      lat = W;
`endif
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].zero, lat, (i % 2) == 1,
             $sformatf("vec%0d", i));
    end

    // Back-to-back: new start issued during the DONE cycle of the previous op
    @(negedge clk);
    launch(24'hC00000, 24'hC00000);
    finish_op(48'h900000000000, 1'b0, model_edges(24'hC00000), 1'b1, "b2b_first");
    start = 1'b1;
    a     = 24'd2;
    b     = 24'd3;
    check("b2b_ready", {63'b0, ready}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op(48'd6, 1'b0, model_edges(24'd3), 1'b1, "b2b_second");

    // Reset partway through RUN discards the operation
    @(negedge clk);
    launch(24'h00FFFF, 24'hFFFFFF);
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_zero", {63'b0, zero}, 64'd1);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_ready", {63'b0, ready}, 64'd1);
    check("midrst_done", {63'b0, done}, 64'd0);
    repeat (2) @(negedge clk);
    resetn    = 1'b1;
    last_prod = '0;
    seen      = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_op(24'd7, 24'd9, 48'd63, 1'b0, model_edges(24'd9), 1'b0, "post_rst");

    // Random operands with varying multiplier bit-lengths
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom) >> $urandom_range(0, W);
      if (i % 7 == 3) ra = '0;
      rp = 48'(ra) * 48'(rb);
      run_op(ra, rb, rp, rp == '0, model_edges(rb), (i % 3) != 0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
